i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  Byte-level I2C master sequencer. Accepts commands of the form [START] byte
//  [STOP] and drives the open-drain SCL/SDA enables with 4-quarter bit timing.
//  Honours slave clock stretching and returns read data and ACK status.
//  SCL/SDA inputs come from the design's SCL/SDA synchronising filters.
// PARAMETERS
//  QTR_CYCLES  250  clk cycles per quarter bit (4*QTR_CYCLES = SCL period); >=2
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command offered
//  cmd_ready  out  1  command accepted when valid&ready
//  cmd_start  in   1  issue START (repeated START if bus already owned)
//  cmd_stop   in   1  issue STOP after the byte
//  cmd_read   in   1  1=read byte, 0=write cmd_wdata
//  cmd_wdata  in   8  write byte, sent MSB first
//  cmd_ack    in   1  read only: 1=master ACKs (drives SDA low on 9th bit)
//  rsp_valid  out  1  one-cycle pulse, command finished (no back-pressure)
//  rsp_rdata  out  8  read byte (holds until next rsp_valid)
//  rsp_nack   out  1  write: SDA level sampled on 9th bit (1=NACK)
//  rsp_err    out  1  command rejected (no START while bus not owned)
//  bus_owned  out  1  high from START until STOP completes
//  scl_in     in   1  filtered SCL level
//  sda_in     in   1  filtered SDA level
//  scl_oe     out  1  1=pull SCL low
//  sda_oe     out  1  1=pull SDA low
// BEHAVIOUR
//  Reset: state IDLE; scl_oe=sda_oe=0, rsp_*=0, bus_owned=0, quarter counter 0.
//  cmd_ready=1 only in IDLE or HOLD; all cmd_* fields captured on acceptance.
//  Quarter timer: counts 0..QTR_CYCLES-1; a quarter ends when count==max.
//  Stretch: in any quarter where SCL is released (bit Q2, STOP P1, START S0),
//   counter frozen while scl_in==0; each low cycle delays everything by 1.
//  START (from IDLE or HOLD): S0 release SDA and SCL (1q); S1 sda_oe=1 (1q);
//   then bit phase.
//  Bit (9 per byte): Q0 scl_oe=1, set sda_oe; Q1 scl_oe=1; Q2 scl_oe=0;
//   Q3 scl_oe=0. sda_in sampled on the cycle Q3 is entered.
//   Data bits: write sda_oe=~bit; read sda_oe=0, shift sda_in in MSB first.
//   9th bit: write sda_oe=0, sample -> rsp_nack; read sda_oe=cmd_ack.
//  After 9th bit: if cmd_stop -> STOP, else HOLD (scl_oe=1, sda_oe=0, owned).
//  STOP: P0 scl_oe=1 sda_oe=1 (1q); P1 release SCL (1q); P2 release SDA (1q);
//   then IDLE, bus_owned=0.
//  rsp_valid pulses in the cycle after the final quarter of the command.
//  Latency, no stretch, accept edge = cycle 0: rsp_valid at cycle Q*QTR_CYCLES,
//   Q = 36 + 2(start) + 3(stop).
//  cmd_start=0 while IDLE: accepted, no bus activity, rsp_valid+rsp_err next
//   cycle.
//  cmd_start=0 in HOLD: byte continues without START.
//  rst mid-command: outputs to reset values on next edge; no STOP, no rsp.
//  No arbitration-loss detection (single-master bus).
// STRUCTURE
//  i2c_pkg: top-state encoding (IDLE,START,BIT,STOP,HOLD), quarter encoding
//   Q0..Q3, bit count width, START/STOP quarter counts.
//  Sub-module i2c_qtr_timer: prescaler with freeze input, quarter_done pulse.
//  Top: state register, 4-bit bit counter, 8-bit shift register, rsp regs.
// TESTING  (QTR_CYCLES=4; open-drain model: line = ~oe & ~slave_pull)
//  1 write 0xA5 start+stop, slave ACK -> SDA at Q3 = 1,0,1,0,0,1,0,1;
//    rsp_valid at cycle 164, rsp_nack=0; then scl_oe=sda_oe=0, bus_owned=0.
//  2 same, slave leaves SDA high on 9th bit -> rsp_nack=1; STOP still issued.
//  3 read start=0 from HOLD, slave sends 0x3C, cmd_ack=0, stop -> rsp_rdata=0x3C;
//    sda_oe=0 all 9 bits; rsp_valid 156 cycles after accept.
//  4 slave holds SCL low 20 cycles in bit 3 Q2 of test 1 -> rsp at 184, same data.
//  5 start=0 while IDLE -> rsp_valid+rsp_err next cycle, lines never driven;
//    write start=1 in HOLD -> repeated START with SDA falling while SCL high.
//  6 rst during bit 5 -> next cycle scl_oe=sda_oe=0, cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level I2C master: top states, bit quarters,
// bit counter width and START/STOP quarter counts.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } qtr_t;

    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 4'd7;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT      = 4'd8;

    localparam int   START_QTRS   = 2;
    localparam int   STOP_QTRS    = 3;
    localparam qtr_t START_LAST_Q = qtr_t'(START_QTRS - 1);
    localparam qtr_t STOP_LAST_Q  = qtr_t'(STOP_QTRS - 1);

    // SDA pull-down for one bit slot: data bits carry the write byte, the
    // ninth bit is released for a write and carries the master ACK for a read.
    function automatic logic bit_sda_oe(input logic is_read, input logic ack,
                                        input logic ack_slot, input logic data_msb);
        if (ack_slot)
            return is_read ? ack : 1'b0;
        return is_read ? 1'b0 : ~data_msb;
    endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-bit prescaler: counts 0..QTR_CYCLES-1 while running, holds while
// frozen, and flags the last cycle of each quarter.
module i2c_qtr_timer #(
    parameter int QTR_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic freeze,
    output logic quarter_done
);

    localparam int CW = $clog2(QTR_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(QTR_CYCLES - 1);

    logic [CW-1:0] count;

    assign quarter_done = run && !freeze && (count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || !run)
            count <= '0;
        else if (!freeze)
            count <= (count == CNT_MAX) ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: [START] byte [STOP] commands driven onto
// open-drain SCL/SDA enables with four-quarter bit timing and clock stretching.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int QTR_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       bus_owned,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output state_t     dbg_state
);

    // Handshake: a command transfers on every clock edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on state, never on
    // cmd_valid. rsp_valid is a single-cycle pulse with no back-pressure.

    state_t               state;
    qtr_t                 qtr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           shreg;
    logic                 c_stop;
    logic                 c_read;
    logic                 c_ack;
    logic                 nack_smp;
    logic                 qtr_done;
    logic                 run;
    logic                 freeze;
    logic                 accept;
    logic                 last_bit;

    assign cmd_ready = (state == ST_IDLE) || (state == ST_HOLD);
    assign accept    = cmd_valid && cmd_ready;
    assign run       = (state != ST_IDLE) && (state != ST_HOLD);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign dbg_state = state;

    // Only quarters with SCL released can be stretched by a slave.
    assign freeze = !scl_in && ((state == ST_BIT   && qtr == Q2) ||
                                (state == ST_STOP  && qtr == Q1) ||
                                (state == ST_START && qtr == Q0));

    i2c_qtr_timer #(
        .QTR_CYCLES(QTR_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .freeze      (freeze),
        .quarter_done(qtr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            qtr       <= Q0;
            bit_cnt   <= '0;
            shreg     <= '0;
            c_stop    <= 1'b0;
            c_read    <= 1'b0;
            c_ack     <= 1'b0;
            nack_smp  <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            bus_owned <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        c_stop  <= cmd_stop;
                        c_read  <= cmd_read;
                        c_ack   <= cmd_ack;
                        shreg   <= cmd_wdata;
                        qtr     <= Q0;
                        bit_cnt <= '0;
                        if (cmd_start) begin
                            state     <= ST_START;
                            scl_oe    <= 1'b0;
                            sda_oe    <= 1'b0;
                            bus_owned <= 1'b1;
                        end else if (state == ST_HOLD) begin
                            state  <= ST_BIT;
                            scl_oe <= 1'b1;
                            sda_oe <= bit_sda_oe(cmd_read, cmd_ack, 1'b0, cmd_wdata[7]);
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_nack  <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    if (qtr_done) begin
                        if (qtr == START_LAST_Q) begin
                            state  <= ST_BIT;
                            qtr    <= Q0;
                            scl_oe <= 1'b1;
                            sda_oe <= bit_sda_oe(c_read, c_ack, 1'b0, shreg[7]);
                        end else begin
                            qtr    <= Q1;
                            sda_oe <= 1'b1;
                        end
                    end
                end
                ST_BIT: begin
                    if (qtr_done) begin
                        case (qtr)
                            Q0: qtr <= Q1;
                            Q1: begin
                                qtr    <= Q2;
                                scl_oe <= 1'b0;
                            end
                            Q2: begin
                                qtr <= Q3;
                                // Writes shift too, so shreg[7] always holds the next bit to send.
                                if (last_bit)
                                    nack_smp <= sda_in;
                                else
                                    shreg <= {shreg[6:0], sda_in};
                            end
                            default: begin
                                qtr    <= Q0;
                                scl_oe <= 1'b1;
                                if (!last_bit) begin
                                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                                    sda_oe  <= bit_sda_oe(c_read, c_ack,
                                                          bit_cnt == LAST_DATA_BIT, shreg[7]);
                                end else if (c_stop) begin
                                    state  <= ST_STOP;
                                    sda_oe <= 1'b1;
                                end else begin
                                    state     <= ST_HOLD;
                                    sda_oe    <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b0;
                                    rsp_nack  <= c_read ? 1'b0 : nack_smp;
                                    if (c_read)
                                        rsp_rdata <= shreg;
                                end
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (qtr_done) begin
                        if (qtr == STOP_LAST_Q) begin
                            state     <= ST_IDLE;
                            qtr       <= Q0;
                            bus_owned <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_nack  <= c_read ? 1'b0 : nack_smp;
                            if (c_read)
                                rsp_rdata <= shreg;
                        end else if (qtr == Q0) begin
                            qtr    <= Q1;
                            scl_oe <= 1'b0;
                        end else begin
                            qtr    <= Q2;
                            sda_oe <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a quarter-level bus model expands each command
// into expected per-cycle outputs and slave line drive, checked every cycle.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int QC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_ack = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, bus_owned, scl_oe, sda_oe;
    logic [7:0] rsp_rdata;
    state_t     dut_state;
    logic       slave_scl_pull = 1'b0;
    logic       slave_sda_pull = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = ~scl_oe & ~slave_scl_pull;
    assign sda_line = ~sda_oe & ~slave_sda_pull;

    i2c_master_ctrl #(.QTR_CYCLES(QC)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .cmd_read (cmd_read),
        .cmd_wdata(cmd_wdata),
        .cmd_ack  (cmd_ack),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_nack (rsp_nack),
        .rsp_err  (rsp_err),
        .bus_owned(bus_owned),
        .scl_in   (scl_line),
        .sda_in   (sda_line),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .dbg_state(dut_state)
    );

    always #5 clk = ~clk;

    // outs = {scl_oe, sda_oe, rsp_valid, bus_owned, cmd_ready}
    typedef struct packed {
        logic [4:0] outs;
        logic       scl_pull;
        logic       sda_pull;
        logic [8:0] idx;
        logic [3:0] q3_bit;
        logic       chk_rsp;
        logic       exp_nack;
        logic       exp_err;
        logic       chk_rdata;
        logic [7:0] exp_rdata;
    } cyc_t;

    cyc_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         qn = 0;
    int         rsp_lat = -1;
    int         start_cnt = 0;
    logic [7:0] obs_bits = 8'h00;
    logic       m_owned = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    string      tname = "reset";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_idle(input logic [4:0] outs, input int n);
        cyc_t e;
        for (int c = 0; c < n; c++) begin
            e = '0;
            e.outs = outs;
            e.idx = qn[8:0];
            e.q3_bit = 4'hF;
            exp_q.push_back(e);
            qn++;
        end
    endtask

    task automatic push_q(input logic scl, input logic sda, input logic spull,
                          input int stretch, input logic [3:0] q3b);
        cyc_t e;
        for (int c = 0; c < QC + stretch; c++) begin
            e = '0;
            e.outs = {scl, sda, 1'b0, 1'b1, 1'b0};
            e.scl_pull = (c < stretch);
            e.sda_pull = spull;
            e.idx = qn[8:0];
            e.q3_bit = (c == 0) ? q3b : 4'hF;
            exp_q.push_back(e);
            qn++;
        end
    endtask

    // Bus-level model: one command becomes its list of quarters, each QC cycles long.
    task automatic model_cmd(input logic start, input logic stop, input logic rd,
                             input logic [7:0] wdata, input logic ack,
                             input logic [7:0] sbyte, input logic sack,
                             input int st_bit, input int st_len);
        logic       d, sp;
        logic [3:0] qb;
        cyc_t       e;
        qn = 0;
        if (!start && !m_owned) begin
            e = '0;
            e.outs = 5'b00101;
            e.q3_bit = 4'hF;
            e.chk_rsp = 1'b1;
            e.exp_err = 1'b1;
            exp_q.push_back(e);
            qn++;
            push_idle(5'b00001, 6);
            return;
        end
        if (start) begin
            push_q(1'b0, 1'b0, 1'b0, 0, 4'hF);
            push_q(1'b0, 1'b1, 1'b0, 0, 4'hF);
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                d  = rd ? 1'b0 : ~wdata[7-i];
                sp = rd ? ~sbyte[7-i] : 1'b0;
                qb = i[3:0];
            end else begin
                d  = rd ? ack : 1'b0;
                sp = rd ? 1'b0 : sack;
                qb = 4'hF;
            end
            push_q(1'b1, d, sp, 0, 4'hF);
            push_q(1'b1, d, sp, 0, 4'hF);
            push_q(1'b0, d, sp, (i == st_bit) ? st_len : 0, 4'hF);
            push_q(1'b0, d, sp, 0, qb);
        end
        if (stop) begin
            push_q(1'b1, 1'b1, 1'b0, 0, 4'hF);
            push_q(1'b0, 1'b1, 1'b0, 0, 4'hF);
            push_q(1'b0, 1'b0, 1'b0, 0, 4'hF);
        end
        e = '0;
        e.outs = stop ? 5'b00101 : 5'b10111;
        e.idx = qn[8:0];
        e.q3_bit = 4'hF;
        e.chk_rsp = 1'b1;
        e.exp_nack = rd ? 1'b0 : ~sack;
        e.chk_rdata = rd;
        e.exp_rdata = sbyte;
        exp_q.push_back(e);
        qn++;
        push_idle(stop ? 5'b00001 : 5'b10011, 3);
        m_owned = !stop;
    endtask

    // Applies slave drive for each cycle and compares the DUT to the model.
    initial begin
        cyc_t cur;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                slave_scl_pull = cur.scl_pull;
                slave_sda_pull = cur.sda_pull;
                @(negedge clk);
                check($sformatf("%s c%0d outs", tname, cur.idx),
                      {27'd0, scl_oe, sda_oe, rsp_valid, bus_owned, cmd_ready}, {27'd0, cur.outs});
                if (cur.chk_rsp)
                    check($sformatf("%s rsp nack/err", tname), {30'd0, rsp_nack, rsp_err},
                          {30'd0, cur.exp_nack, cur.exp_err});
                if (cur.chk_rdata)
                    check($sformatf("%s rdata", tname), {24'd0, rsp_rdata}, {24'd0, cur.exp_rdata});
                if (rsp_valid)
                    rsp_lat = int'(cur.idx);
                if (cur.q3_bit != 4'hF)
                    obs_bits[7 - int'(cur.q3_bit)] = sda_line;
                if (prev_scl && scl_line && prev_sda && !sda_line)
                    start_cnt++;
                prev_scl = scl_line;
                prev_sda = sda_line;
            end else begin
                slave_scl_pull = 1'b0;
                slave_sda_pull = 1'b0;
            end
        end
    end

    task automatic send(input string name, input logic start, input logic stop, input logic rd,
                        input logic [7:0] wdata, input logic ack, input logic [7:0] sbyte,
                        input logic sack, input int st_bit, input int st_len);
        @(negedge clk);
        tname = name;
        rsp_lat = -1;
        obs_bits = 8'h00;
        cmd_valid = 1'b1;
        cmd_start = start;
        cmd_stop = stop;
        cmd_read = rd;
        cmd_wdata = wdata;
        cmd_ack = ack;
        model_cmd(start, stop, rd, wdata, ack, sbyte, sack, st_bit, st_len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: %0d expected cycles left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outs", {27'd0, scl_oe, sda_oe, rsp_valid, bus_owned, cmd_ready}, 32'b00001);
        check("reset rsp regs", {22'd0, rsp_rdata, rsp_nack, rsp_err}, 32'd0);
        check("reset state", {29'd0, dut_state}, {29'd0, ST_IDLE});
        rst = 1'b0;

        send("t1_wr_a5", 1, 1, 0, 8'hA5, 0, 8'h00, 1, -1, 0);
        check("t1 latency", rsp_lat, 164);
        check("t1 sda at q3", {24'd0, obs_bits}, 32'hA5);
        check("t1 nack", {31'd0, rsp_nack}, 32'd0);
        check("t1 idle lines", {29'd0, scl_oe, sda_oe, bus_owned}, 32'd0);

        send("t2_wr_nack", 1, 1, 0, 8'hA5, 0, 8'h00, 0, -1, 0);
        check("t2 latency", rsp_lat, 164);
        check("t2 nack", {31'd0, rsp_nack}, 32'd1);

        send("t3_setup_hold", 1, 0, 0, 8'h5A, 0, 8'h00, 1, -1, 0);
        check("t3 setup latency", rsp_lat, 152);
        check("t3 setup owned", {31'd0, bus_owned}, 32'd1);
        send("t3_rd_3c", 0, 1, 1, 8'h00, 0, 8'h3C, 0, -1, 0);
        check("t3 latency", rsp_lat, 156);
        check("t3 rdata", {24'd0, rsp_rdata}, 32'h3C);

        send("t4_stretch", 1, 1, 0, 8'hA5, 0, 8'h00, 1, 3, 20);
        check("t4 latency", rsp_lat, 184);
        check("t4 sda at q3", {24'd0, obs_bits}, 32'hA5);
        check("t4 nack", {31'd0, rsp_nack}, 32'd0);

        send("t5_err", 0, 0, 0, 8'h00, 0, 8'h00, 0, -1, 0);
        check("t5 err latency", rsp_lat, 0);
        check("t5 err flag", {31'd0, rsp_err}, 32'd1);
        send("t5_hold", 1, 0, 0, 8'h81, 0, 8'h00, 1, -1, 0);
        start_cnt = 0;
        send("t5_rstart", 1, 1, 0, 8'h42, 0, 8'h00, 1, -1, 0);
        check("t5 repeated start edges", start_cnt, 1);
        check("t5 rstart latency", rsp_lat, 164);

        tname = "t6";
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_start = 1'b1;
        cmd_stop = 1'b1;
        cmd_read = 1'b0;
        cmd_wdata = 8'hFF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (90) @(negedge clk);
        check("t6 busy in bit 5", {30'd0, bus_owned, scl_oe}, 32'b11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6 outs after rst", {27'd0, scl_oe, sda_oe, rsp_valid, bus_owned, cmd_ready}, 32'b00001);
        check("t6 rsp regs after rst", {22'd0, rsp_rdata, rsp_nack, rsp_err}, 32'd0);
        check("t6 state after rst", {29'd0, dut_state}, {29'd0, ST_IDLE});
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_valid || scl_oe || sda_oe) seen++;
        end
        check("t6 quiet after rst", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached in %s", tname);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
